// File: rtl/prio_arbiter4_ctrl_pkg.sv
// Shared constants and state encoding for the 4-requester priority arbiter.
package prio_arbiter4_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/prio_pick4.sv
// Combinational winner selection: descending search over the request bits.
// Fixed mode always starts at index 3; round-robin mode starts at start_i and
// wraps from 0 back to 3. The first asserted bit found wins.
module prio_pick4
  import prio_arbiter4_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  input  logic               mode_i,
  output logic [ID_W-1:0]    id_o,
  output logic               found_o
);

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] idx;
  logic            hit;
  logic [ID_W-1:0] hit_id;

  // Walk the four indices from the start point downward; keep the first hit.
  always_comb begin
    base   = mode_i ? start_i : ID_W'(NUM_REQ - 1);
    idx    = '0;
    hit    = 1'b0;
    hit_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = base - ID_W'(i);
      if (!hit && req_i[idx]) begin
        hit    = 1'b1;
        hit_id = idx;
      end
    end
    id_o    = hit_id;
    found_o = hit;
  end

endmodule

// File: rtl/prio_arbiter4_ctrl.sv
// Arbiter for one shared resource among four requesters. A grant is issued
// from IDLE, held in GRANT until done, owner withdrawal or hold timeout, and
// IDLE always lasts at least one cycle between owners.
// Handshake: req is a level; a grant, once registered, is kept while the
// owner's req stays high and done is low; done is sampled only in GRANT.
module prio_arbiter4_ctrl
  import prio_arbiter4_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               timeout,
  output logic               dbg_state_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic               tmo_hit;
  logic               owner_drop;

  // Round-robin search begins one below the previous owner.
  prio_pick4 u_pick (
    .req_i   (req),
    .start_i (last_id_q - 2'd1),
    .mode_i  (mode),
    .id_o    (pick_id),
    .found_o (pick_found)
  );

  assign tmo_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign owner_drop = ~req[grant_id_q];

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          grant_d    = NUM_REQ'(1) << pick_id;
          grant_id_d = pick_id;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done || owner_drop || tmo_hit) begin
          grant_d   = '0;
          last_id_d = grant_id_q;
          timeout_d = tmo_hit && !done && !owner_drop;
          state_d   = ST_IDLE;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;

endmodule
